// File: rtl/solver_dispatch.sv
// Multi-core nonce dispatcher: splits the nonce space across NUM_CORES solvers, sequences their reset/run, and arbitrates the first solution.
// Optional watchdog: define SOLVER_DISPATCH_TIMEOUT_EN.
module solver_dispatch #(
   parameter int          NUM_CORES     = 4,
   parameter int          NONCE_W       = 32,
   parameter int          DIV_W         = 16,
   parameter int          RST_TICKS     = 2,
   parameter logic [31:0] TIMEOUT_TICKS = 32'hFFFF_FFFF
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic                                               abort,
   input  logic [DIV_W-1:0]                                   div_cfg,
   output logic                                               core_tick,
   output logic [NUM_CORES-1:0]                               core_rst_n,
   output logic [NUM_CORES*NONCE_W-1:0]                       core_nonce_base,
   input  logic [NUM_CORES-1:0]                               core_found,
   input  logic [NUM_CORES-1:0]                               core_done,
   input  logic [NUM_CORES*NONCE_W-1:0]                       core_nonce,
   output logic [2:0]                                         state_out,
   output logic [NONCE_W-1:0]                                 nonce_out,
   output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] winner,
   output logic                                               timeout
);

   localparam int WIN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int SHIFT = NONCE_W - $clog2(NUM_CORES);
   localparam int RC_W  = (RST_TICKS > 1) ? $clog2(RST_TICKS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'b000,
      ST_RESET     = 3'b001,
      ST_RUN       = 3'b010,
      ST_EXHAUSTED = 3'b011,
      ST_FOUND     = 3'b100
   } state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [RC_W-1:0]    rst_cnt;
   logic [WIN_W-1:0]   low_idx;
   logic [NONCE_W-1:0] low_nonce;

   assign state_out = state;

   // Lowest-index found core wins the arbitration.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         low_idx = core_found[i] ? WIN_W'(i) : low_idx;
      end
      low_nonce = core_nonce[int'(low_idx)*NONCE_W +: NONCE_W];
   end

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
   logic [NONCE_W-1:0] to_cnt;
   logic               timeout_flag;
   assign timeout = timeout_flag;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_TICKS;
   assign timeout = 1'b0;
`endif

   // Free-running tick divider plus the dispatcher state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         div_cnt    <= '0;
         core_tick  <= 1'b0;
         core_rst_n <= '0;
         nonce_out  <= '0;
         winner     <= '0;
         rst_cnt    <= '0;
`ifdef SOLVER_DISPATCH_TIMEOUT_EN
         to_cnt       <= '0;
         timeout_flag <= 1'b0;
`endif
         for (int i = 0; i < NUM_CORES; i++) begin
            core_nonce_base[i*NONCE_W +: NONCE_W] <= NONCE_W'(i) << SHIFT;
         end
      end else begin
         // >= rather than == so a shrinking div_cfg never lets the count run away.
         if (div_cnt >= div_cfg) begin
            div_cnt   <= '0;
            core_tick <= 1'b1;
         end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
            core_tick <= 1'b0;
         end

         if (abort && (state != ST_IDLE)) begin
            state      <= ST_IDLE;
            core_rst_n <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                  core_rst_n <= '0;
                  if (start) begin
                     state     <= ST_RESET;
                     nonce_out <= '0;
                     winner    <= '0;
                     rst_cnt   <= '0;
`ifdef SOLVER_DISPATCH_TIMEOUT_EN
                     to_cnt       <= '0;
                     timeout_flag <= 1'b0;
`endif
                  end
               end
               ST_RESET: begin
                  if (core_tick) begin
                     if (rst_cnt == RC_W'(RST_TICKS - 1)) begin
                        state      <= ST_RUN;
                        core_rst_n <= '1;
                     end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                     end
                  end
               end
               ST_RUN: begin
                  if (|core_found) begin
                     state      <= ST_FOUND;
                     core_rst_n <= '0;
                     winner     <= low_idx;
                     nonce_out  <= low_nonce;
                  end else if (&core_done) begin
                     state      <= ST_EXHAUSTED;
                     core_rst_n <= '0;
                  end else begin
`ifdef SOLVER_DISPATCH_TIMEOUT_EN
                     if (core_tick) begin
                        to_cnt <= to_cnt + NONCE_W'(1);
                        if ((to_cnt + NONCE_W'(1)) == NONCE_W'(TIMEOUT_TICKS)) begin
                           state        <= ST_EXHAUSTED;
                           core_rst_n   <= '0;
                           timeout_flag <= 1'b1;
                        end
                     end
`endif
                  end
               end
               default: begin
                  state      <= ST_IDLE;
                  core_rst_n <= '0;
               end
            endcase
         end
      end
   end

endmodule
